// File: rtl/decode_operand_stage_if.sv
// Bus bundle between the decode stage and its neighbours: upstream
// instruction handshake, register-file read port, writeback snoop and the
// decoded bundle handed to execute.
interface decode_operand_stage_if #(
    parameter int XLEN = 32
);
    // Upstream instruction handshake
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr_in;
    logic [XLEN-1:0] pc_in;

    // Register-file read port (addresses out, registered data back)
    logic [4:0]      rf_read_address_1;
    logic [4:0]      rf_read_address_2;
    logic [XLEN-1:0] rf_data_1;
    logic [XLEN-1:0] rf_data_2;

    // Copy of the register-file write port, used for same-edge bypass
    logic            wb_write_enable;
    logic [4:0]      wb_write_address;
    logic [XLEN-1:0] wb_write_data;

    // Decoded bundle towards execute
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_operand_1;
    logic [XLEN-1:0] out_operand_2;
    logic            out_writes_rd;
    logic            out_illegal;

    // Environment side: feeds instructions, register data and writebacks.
    modport master (
        output in_valid, instr_in, pc_in,
        output rf_data_1, rf_data_2,
        output wb_write_enable, wb_write_address, wb_write_data,
        output out_ready,
        input  in_ready, rf_read_address_1, rf_read_address_2,
        input  out_valid, out_pc, out_opcode, out_rd, out_funct3, out_funct7,
        input  out_imm, out_operand_1, out_operand_2, out_writes_rd, out_illegal
    );

    // Decode stage side.
    modport slave (
        input  in_valid, instr_in, pc_in,
        input  rf_data_1, rf_data_2,
        input  wb_write_enable, wb_write_address, wb_write_data,
        input  out_ready,
        output in_ready, rf_read_address_1, rf_read_address_2,
        output out_valid, out_pc, out_opcode, out_rd, out_funct3, out_funct7,
        output out_imm, out_operand_1, out_operand_2, out_writes_rd, out_illegal
    );
endinterface

// File: rtl/decode_operand_stage.sv
// RV32I decode stage in front of a 32x32 register file with a one-cycle
// registered read. Source addresses are driven in the accept cycle so the
// register data arrives together with the decoded bundle; a writeback that
// lands on the same edge as the read is bypassed.
module decode_operand_stage #(
    parameter int XLEN      = 32,
    parameter bit BYPASS_EN = 1'b1
) (
    input logic                   clock,
    input logic                   reset,
    decode_operand_stage_if.slave bus
);

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    // Only the source-register fields of the held instruction are ever used;
    // both are zero in the reset NOP (addi x0,x0,0).
    logic [4:0]      held_rs1;
    logic [4:0]      held_rs2;
    logic            accept;

    logic            hit_1;
    logic            hit_2;
    logic            flag_1;
    logic            flag_2;
    logic [XLEN-1:0] byp_1;
    logic [XLEN-1:0] byp_2;

    logic [6:0]      dec_opcode;
    logic [4:0]      dec_rd;
    logic [31:0]     dec_imm;
    logic            dec_rd_class;
    logic            dec_writes_rd;
    logic            dec_illegal;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // The register file latches these on the accept edge, so its data is
    // valid exactly when out_valid rises; while stalled it keeps re-reading
    // the held sources and therefore tracks writes landing during the stall.
    assign bus.rf_read_address_1 = accept ? bus.instr_in[19:15] : held_rs1;
    assign bus.rf_read_address_2 = accept ? bus.instr_in[24:20] : held_rs2;

    // A write hitting a source on the read edge is invisible in the registered
    // read data, so it is captured here instead. x0 never bypasses.
    assign hit_1 = BYPASS_EN && bus.wb_write_enable && (bus.wb_write_address != 5'd0)
                   && (bus.wb_write_address == bus.rf_read_address_1);
    assign hit_2 = BYPASS_EN && bus.wb_write_enable && (bus.wb_write_address != 5'd0)
                   && (bus.wb_write_address == bus.rf_read_address_2);

    assign bus.out_operand_1 = flag_1 ? byp_1 : bus.rf_data_1;
    assign bus.out_operand_2 = flag_2 ? byp_2 : bus.rf_data_2;

    assign dec_opcode = bus.instr_in[6:0];
    assign dec_rd     = bus.instr_in[11:7];

    // Immediate extraction and classification of the incoming instruction.
    // Every listed opcode ends in 2'b11, so a bad low pair also lands in default.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        dec_imm      = '0;
        dec_rd_class = 1'b0;
        dec_illegal  = 1'b0;
        case (dec_opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                dec_imm      = {{20{bus.instr_in[31]}}, bus.instr_in[31:20]};
                dec_rd_class = 1'b1;
            end
            OPC_SYSTEM: begin
                dec_imm = {{20{bus.instr_in[31]}}, bus.instr_in[31:20]};
            end
            OPC_STORE: begin
                dec_imm = {{20{bus.instr_in[31]}}, bus.instr_in[31:25], bus.instr_in[11:7]};
            end
            OPC_BRANCH: begin
                dec_imm = {{19{bus.instr_in[31]}}, bus.instr_in[31], bus.instr_in[7],
                           bus.instr_in[30:25], bus.instr_in[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_imm      = {bus.instr_in[31:12], 12'h000};
                dec_rd_class = 1'b1;
            end
            OPC_JAL: begin
                dec_imm      = {{11{bus.instr_in[31]}}, bus.instr_in[31], bus.instr_in[19:12],
                                bus.instr_in[20], bus.instr_in[30:21], 1'b0};
                dec_rd_class = 1'b1;
            end
            OPC_OP: begin
                dec_rd_class = 1'b1;
            end
            OPC_MISC_MEM: begin
                dec_imm = '0;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        dec_writes_rd = dec_rd_class && (dec_rd != 5'd0);
    end

    // Bundle register: load on accept, drop valid when consumed, else hold.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: the reset is asynchronous, so it sits in the sensitivity list
        // and takes effect (addresses back to x0) without waiting for a clock.
        if (!reset) begin
            held_rs1          <= 5'd0;
            held_rs2          <= 5'd0;
            bus.out_valid     <= 1'b0;
            bus.out_pc        <= '0;
            bus.out_opcode    <= '0;
            bus.out_rd        <= '0;
            bus.out_funct3    <= '0;
            bus.out_funct7    <= '0;
            bus.out_imm       <= '0;
            bus.out_writes_rd <= 1'b0;
            bus.out_illegal   <= 1'b0;
        end else if (accept) begin
            // NOTE: state registers use non-blocking assignment so every
            // register samples pre-edge values regardless of statement order.
            held_rs1          <= bus.instr_in[19:15];
            held_rs2          <= bus.instr_in[24:20];
            bus.out_valid     <= 1'b1;
            bus.out_pc        <= bus.pc_in;
            bus.out_opcode    <= dec_opcode;
            bus.out_rd        <= dec_rd;
            bus.out_funct3    <= bus.instr_in[14:12];
            bus.out_funct7    <= bus.instr_in[31:25];
            bus.out_imm       <= dec_imm;
            bus.out_writes_rd <= dec_writes_rd;
            bus.out_illegal   <= dec_illegal;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // Bypass capture, re-evaluated on every edge alongside the register read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flag_1 <= 1'b0;
            flag_2 <= 1'b0;
            byp_1  <= '0;
            byp_2  <= '0;
        end else begin
            flag_1 <= hit_1;
            flag_2 <= hit_2;
            if (hit_1) begin
                byp_1 <= bus.wb_write_data;
            end
            if (hit_2) begin
                byp_2 <= bus.wb_write_data;
            end
        end
    end

endmodule

// File: tb/tb_decode_operand_stage.sv
// Bench for decode_operand_stage: a behavioural register file with a
// registered read port, plus an architectural reference that expects each
// operand to equal the current value of its source register.
module tb_decode_operand_stage;

    logic clock;
    logic reset;
    logic rf_init;

    int checks;
    int failures;

    decode_operand_stage_if #(.XLEN(32)) bus ();

    decode_operand_stage #(
        .XLEN      (32),
        .BYPASS_EN (1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file: addresses sampled on the edge, data returned registered;
    // a read of the register being written on the same edge returns old data.
    logic [31:0] regs [32];
    always @(posedge clock) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i) * 32'h0000_0101;
            end
            bus.rf_data_1 <= '0;
            bus.rf_data_2 <= '0;
        end else begin
            bus.rf_data_1 <= regs[bus.rf_read_address_1];
            bus.rf_data_2 <= regs[bus.rf_read_address_2];
            if (bus.wb_write_enable && bus.wb_write_address != 5'd0) begin
                regs[bus.wb_write_address] <= bus.wb_write_data;
            end
        end
    end

    // Reference state: what execute should currently see.
    logic        m_valid;
    logic        m_has;
    logic [31:0] m_instr;
    logic [31:0] m_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Instruction format letter from the opcode table; 'X' = unsupported.
    function automatic byte ref_fmt(input logic [31:0] ins);
        case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: return "I";
            7'b0100011: return "S";
            7'b1100011: return "B";
            7'b0110111, 7'b0010111: return "U";
            7'b1101111: return "J";
            7'b0110011: return "R";
            7'b0001111: return "F";
            default:    return "X";
        endcase
    endfunction

    // Immediate rebuilt as a signed integer from weighted bit groups.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int v;
        v = 0;
        case (ref_fmt(ins))
            "I": v = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
            "S": v = (ins[31] ? -2048 : 0) + int'(ins[30:25]) * 32 + int'(ins[11:7]);
            "B": v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                     + int'(ins[11:8]) * 2;
            "U": v = int'(ins[31:12]) * 4096;
            "J": v = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096
                     + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic ref_writes(input logic [31:0] ins);
        logic cls;
        cls = ins[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                               7'b0000011, 7'b0010011, 7'b0110011};
        return cls && (ins[11:7] != 5'd0);
    endfunction

    task automatic check_outputs();
        logic [31:0] ins;
        ins = m_instr;
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        if (m_has) begin
            check("out_pc",        bus.out_pc,               m_pc);
            check("out_opcode",    32'(bus.out_opcode),      32'(ins[6:0]));
            check("out_rd",        32'(bus.out_rd),          32'(ins[11:7]));
            check("out_funct3",    32'(bus.out_funct3),      32'(ins[14:12]));
            check("out_funct7",    32'(bus.out_funct7),      32'(ins[31:25]));
            check("out_imm",       bus.out_imm,              ref_imm(ins));
            check("out_writes_rd", 32'(bus.out_writes_rd),   32'(ref_writes(ins)));
            check("out_illegal",   32'(bus.out_illegal),     32'(ref_fmt(ins) == "X"));
        end else begin
            check("rst_pc",      bus.out_pc,              32'd0);
            check("rst_opcode",  32'(bus.out_opcode),     32'd0);
            check("rst_imm",     bus.out_imm,             32'd0);
            check("rst_writes",  32'(bus.out_writes_rd),  32'd0);
            check("rst_illegal", 32'(bus.out_illegal),    32'd0);
        end
        if (m_valid) begin
            check("operand_1", bus.out_operand_1, regs[ins[19:15]]);
            check("operand_2", bus.out_operand_2, regs[ins[24:20]]);
        end
    endtask

    // One clock: inputs are already set (at a negedge); check the
    // combinational handshake/addresses, step the model, check the bundle.
    task automatic cycle();
        logic        acc;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        rdy;
        #1;
        ins = bus.instr_in;
        pc  = bus.pc_in;
        rdy = bus.out_ready;
        acc = bus.in_valid && (!m_valid || rdy);
        check("in_ready", 32'(bus.in_ready), 32'(!m_valid || rdy));
        check("rd_addr_1", 32'(bus.rf_read_address_1), 32'(acc ? ins[19:15] : m_instr[19:15]));
        check("rd_addr_2", 32'(bus.rf_read_address_2), 32'(acc ? ins[24:20] : m_instr[24:20]));
        @(posedge clock);
        if (acc) begin
            m_valid = 1'b1;
            m_has   = 1'b1;
            m_instr = ins;
            m_pc    = pc;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        @(negedge clock);
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy);
        bus.in_valid  = v;
        bus.instr_in  = ins;
        bus.pc_in     = pc;
        bus.out_ready = rdy;
    endtask

    task automatic drive_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.wb_write_enable  = we;
        bus.wb_write_address = a;
        bus.wb_write_data    = d;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_has   = 1'b0;
        m_instr = 32'h0000_0013;
        m_pc    = 32'd0;
    endtask

    logic [6:0] opc_list [11] = '{7'b0000011, 7'b0001111, 7'b0010011, 7'b0010111,
                                  7'b0100011, 7'b0110011, 7'b0110111, 7'b1100011,
                                  7'b1100111, 7'b1101111, 7'b1110011};

    initial begin
        logic [31:0] r;
        logic [31:0] ins;
        checks   = 0;
        failures = 0;
        model_reset();
        reset   = 1'b0;
        rf_init = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        drive_wb(1'b0, 5'd0, 32'd0);

        // Reset state, then release.
        repeat (3) @(negedge clock);
        rf_init = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_addr_1", 32'(bus.rf_read_address_1), 32'd0);
        check("rst_addr_2", 32'(bus.rf_read_address_2), 32'd0);
        check_outputs();
        @(negedge clock);
        reset = 1'b1;
        cycle();

        // addi x1,x0,5
        drive(1'b1, 32'h0050_0093, 32'h0000_0100, 1'b1);
        cycle();
        check("addi_imm", bus.out_imm, 32'd5);
        check("addi_rd", 32'(bus.out_rd), 32'd1);
        check("addi_writes", 32'(bus.out_writes_rd), 32'd1);
        check("addi_op1_x0", bus.out_operand_1, 32'd0);

        // add x3,x1,x2 with x1 written on the accept edge
        drive(1'b1, 32'h0020_81B3, 32'h0000_0104, 1'b1);
        drive_wb(1'b1, 5'd1, 32'h0000_DEAD);
        cycle();
        drive_wb(1'b0, 5'd0, 32'd0);
        check("add_byp_op1", bus.out_operand_1, 32'h0000_DEAD);

        // Three-cycle stall, x2 written on the second edge
        drive(1'b1, 32'h0000_0013, 32'h0000_0108, 1'b0);
        cycle();
        drive_wb(1'b1, 5'd2, 32'h0000_0055);
        cycle();
        drive_wb(1'b0, 5'd0, 32'd0);
        check("stall_byp_op2", bus.out_operand_2, 32'h0000_0055);
        cycle();
        check("stall_rf_op2", bus.out_operand_2, 32'h0000_0055);
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);

        // Store then branch, accepted back to back
        drive(1'b1, 32'hFE20_AE23, 32'h0000_0200, 1'b1);
        cycle();
        check("sw_imm", bus.out_imm, 32'hFFFF_FFFC);
        drive(1'b1, 32'hFE00_08E3, 32'h0000_0204, 1'b1);
        cycle();
        check("beq_imm", bus.out_imm, 32'hFFFF_FFF0);
        check("beq_writes", 32'(bus.out_writes_rd), 32'd0);

        // Illegal encodings, back to back with no bubble
        drive(1'b1, 32'h0000_0000, 32'h0000_0300, 1'b1);
        cycle();
        check("ill0_flag", 32'(bus.out_illegal), 32'd1);
        drive(1'b1, 32'h0000_007F, 32'h0000_0304, 1'b1);
        cycle();
        check("ill7f_flag", 32'(bus.out_illegal), 32'd1);
        check("ill7f_valid", 32'(bus.out_valid), 32'd1);
        check("ill7f_pc", bus.out_pc, 32'h0000_0304);

        // Reset in the middle of a stall
        drive(1'b1, 32'h00A5_8513, 32'h0000_0400, 1'b1);
        cycle();
        drive(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0);
        cycle();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_addr_1", 32'(bus.rf_read_address_1), 32'd0);
        check("mid_rst_addr_2", 32'(bus.rf_read_address_2), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        check_outputs();

        // Randomized traffic with writebacks aimed at the low registers
        for (int n = 0; n < 400; n++) begin
            r = $urandom();
            if ($urandom_range(0, 7) == 0) begin
                ins = $urandom();
            end else begin
                ins = {r[31:7], opc_list[$urandom_range(0, 10)]};
            end
            if ($urandom_range(0, 1) == 1) ins[19:15] = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) ins[24:20] = 5'($urandom_range(0, 3));
            drive($urandom_range(0, 3) != 0, ins, {$urandom_range(0, 65535), 2'b00} & 32'hFFFF_FFFC,
                  $urandom_range(0, 3) != 0);
            drive_wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 4)), $urandom());
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_operand_stage.md
Name: decode_operand_stage

Overview:
- Decode stage sitting directly upstream of the 32x32 register file; consumes the previous stage's register-file read data.
- Accepts one RV32I instruction per handshake and drives rs1/rs2 to the register file's read addresses.
- Produces decoded fields and an immediate, aligned to the register file's one-cycle registered read latency.
- Merges the register-file read data with a same-edge writeback bypass to present final operands to execute.

Parameters:
- XLEN, 32, datapath width; fixed at 32 for RV32I.
- BYPASS_EN, 1, 1 enables same-edge writeback bypass; 0 passes register-file data through unmodified.

Ports:
- clock  in  1  rising-edge clock, shared with the register file.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction this cycle.
- instr_in  in  32  instruction word.
- pc_in  in  32  PC of instr_in.
- rf_read_address_1  out  5  to register file read_address_1.
- rf_read_address_2  out  5  to register file read_address_2.
- rf_data_1  in  32  from register file data_out_1.
- rf_data_2  in  32  from register file data_out_2.
- wb_write_enable  in  1  copy of register-file WriteEnable.
- wb_write_address  in  5  copy of register-file write_address.
- wb_write_data  in  32  copy of register-file write_data_in.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- out_pc  out  32  PC of the bundle.
- out_opcode  out  7  instr[6:0].
- out_rd  out  5  instr[11:7].
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_imm  out  32  sign-extended immediate.
- out_operand_1  out  32  rs1 value.
- out_operand_2  out  32  rs2 value.
- out_writes_rd  out  1  instruction writes a nonzero rd.
- out_illegal  out  1  unsupported encoding.

Behaviour:
- Reset (async, reset=0):
  - out_valid=0; every out_* register=0.
  - Held instruction=0x00000013 (NOP), so rf_read_address_1/2=0.
  - Bypass flags=0; bypass data=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - accept = in_valid && in_ready.
- Read address drive (combinational): rf_read_address_1 = accept ? instr_in[19:15] : held[19:15]; rf_read_address_2 likewise using [24:20].
- The register file samples these addresses at the same edge as accept. This makes rf_data valid in the cycle after the edge, coincident with out_valid.
- At each rising edge:
  - If accept: load held, out_pc, and all decoded fields; set out_valid=1.
  - Else if out_ready: clear out_valid; fields hold.
  - Else: hold everything.
- Stall: the register file re-reads the held addresses every edge, so operands track writes that land during the stall.
- Bypass, evaluated every edge for slot k in {1,2}:
  - Set flag_k=1 and byp_k=wb_write_data when BYPASS_EN && wb_write_enable && wb_write_address!=0 && wb_write_address==rf_read_address_k.
  - Otherwise set flag_k=0.
  - out_operand_k = flag_k ? byp_k : rf_data_k (combinational).
  - Address 0 never bypasses; x0 reads 0.
- Immediate, by opcode:
  - I-type (LOAD 0000011, OP-IMM 0010011, JALR 1100111, SYSTEM 1110011): sext(instr[31:20]).
  - S-type (0100011): sext({[31:25],[11:7]}).
  - B-type (1100011): sext({[31],[7],[30:25],[11:8],0}).
  - U-type (LUI 0110111, AUIPC 0010111): {[31:12],12'b0}.
  - J-type (1101111): sext({[31],[19:12],[20],[30:21],0}).
  - OP 0110011, FENCE 0001111: 0.
- out_writes_rd = opcode in {LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP} && rd!=0.
- out_illegal=1 when instr[1:0]!=2'b11 or the opcode is not in the eleven listed. An illegal bundle still passes with out_imm=0 and out_writes_rd=0.
- Simultaneous out_ready and in_valid while out_valid=1: the new bundle replaces the old at the same edge (full throughput, no bubble).
- Reset mid-stall: the bundle is dropped and the addresses return to 0 immediately (asynchronous).

Test Plan:
- Reset low, then release -> out_valid=0, in_ready=1, rf_read_address_1/2=0, out_imm=0.
- Accept 0x00500093 (addi x1,x0,5) with pc_in=0x100, out_ready=1 -> next cycle: out_valid=1, out_rd=1, out_imm=5, out_writes_rd=1, out_pc=0x100, operand_1=rf x0=0.
- Accept 0x002081B3 (add x3,x1,x2) with wb writing x1=0xDEAD at the accept edge -> out_operand_1=0xDEAD, out_operand_2=regfile x2.
- Hold out_ready=0 for 3 cycles; write x2=0x55 on cycle 2 -> in_ready=0, addresses stay 1/2, and out_operand_2=0x55 from the following cycle.
- Accept 0xFE20AE23 (sw x2,-4(x1)) then 0xFE0008E3 (beq x0,x0,-16) -> out_imm=0xFFFFFFFC then 0xFFFFFFF0; out_writes_rd=0 for both.
- Accept 0x00000000 and 0x0000007F -> out_illegal=1, out_writes_rd=0; back-to-back accepts with out_ready=1 show no bubble.
